store_drain_tracker: RTL and testbench

Tracks stores between the load/store unit's store path and the write-through data-cache write buffer. Holds each accepted store in a one-entry output register, issues it downstream, and counts issued-but-unacknowledged stores against the outstanding-store ceiling. Classifies each store as cached or non-cached against the cached DRAM region. Implements the fence drain handshake that holds new stores until every outstanding store is acknowledged.

---
 rtl/store_drain_tracker.sv | 95 +++++++++
 tb/tb_store_drain_tracker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_tracker.sv
// store_drain_tracker: buffers stores to the write buffer, counts unacked stores, drains them on fence
// Ports: clk_i/rst_i clock and sync active-high reset; st_valid_i/st_ready_o/st_addr_i upstream store;
//   st_req_valid_o/st_req_ready_i/st_req_addr_o/st_req_cached_o downstream store; st_ack_i/st_ack_cached_i
//   completions; fence_i/fence_busy_o/fence_done_o fence handshake; outstanding_o, nc_pending_o, err_o status.
// Define STORE_DRAIN_TRACKER_NC_CNT_EN to implement the non-cached outstanding counter behind nc_pending_o.
module store_drain_tracker #(
  parameter int unsigned MaxOutstanding = 7,
  parameter int unsigned PLEN = 34,
  parameter logic [PLEN-1:0] CachedBase = 34'h8000_0000,
  parameter logic [PLEN-1:0] CachedLength = 34'h4000_0000,
  localparam int unsigned CW = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            st_valid_i,
  output logic            st_ready_o,
  input  logic [PLEN-1:0] st_addr_i,
  output logic            st_req_valid_o,
  input  logic            st_req_ready_i,
  output logic [PLEN-1:0] st_req_addr_o,
  output logic            st_req_cached_o,
  input  logic            st_ack_i,
  input  logic            st_ack_cached_i,
  input  logic            fence_i,
  output logic            fence_busy_o,
  output logic            fence_done_o,
  output logic [CW-1:0]   outstanding_o,
  output logic            nc_pending_o,
  output logic            err_o
);
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic buf_valid, buf_cached, issue, accept, cached, err_set;
  logic [PLEN-1:0] buf_addr;
  logic [CW-1:0] cnt, cnt_nxt;
  // region end kept one bit wider so base + length never wraps
  logic [PLEN:0] region_end;
  assign region_end = {1'b0, CachedBase} + {1'b0, CachedLength};
  assign cached = ({1'b0, st_addr_i} >= {1'b0, CachedBase}) & ({1'b0, st_addr_i} < region_end);
  assign st_req_valid_o = buf_valid & (cnt < CW'(MaxOutstanding));
  assign issue = st_req_valid_o & st_req_ready_i;
  assign st_ready_o = (state == IDLE) & (~buf_valid | issue);
  assign accept = st_valid_i & st_ready_o;
  assign st_req_addr_o = buf_addr;
  assign st_req_cached_o = buf_cached;
  assign outstanding_o = cnt;
  assign fence_busy_o = state != IDLE;
  assign fence_done_o = state == DONE;
  // an ack alone at zero is a protocol error; the count saturates instead of wrapping
  assign err_set = st_ack_i & ~issue & (cnt == '0);
  always_comb begin
    cnt_nxt = (issue & ~st_ack_i) ? cnt + 1'b1 : (st_ack_i & ~issue & ~err_set) ? cnt - 1'b1 : cnt;
    state_nxt = (state == IDLE) ? (fence_i ? DRAIN : IDLE) :
                (state == DRAIN) ? ((~buf_valid & (cnt == '0)) ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      buf_valid <= 1'b0;
      buf_addr <= '0;
      buf_cached <= 1'b0;
      cnt <= '0;
      err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      err_o <= err_o | err_set;
      if (accept) begin
        buf_valid <= 1'b1;
        buf_addr <= st_addr_i;
        buf_cached <= cached;
      end else if (issue) begin
        buf_valid <= 1'b0;
      end
    end
  end
`ifdef STORE_DRAIN_TRACKER_NC_CNT_EN
  logic [CW-1:0] ncnt, ncnt_nxt;
  logic nc_inc, nc_dec;
  assign nc_inc = issue & ~buf_cached;
  assign nc_dec = st_ack_i & ~st_ack_cached_i;
  assign nc_pending_o = ncnt != '0;
  always_comb begin
    ncnt_nxt = (nc_inc & ~nc_dec) ? ncnt + 1'b1 : (nc_dec & ~nc_inc & (ncnt != '0)) ? ncnt - 1'b1 : ncnt;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) ncnt <= '0;
    else ncnt <= ncnt_nxt;
  end
`else
  logic unused_ack_cached;
  assign unused_ack_cached = st_ack_cached_i;
  assign nc_pending_o = 1'b0;
`endif
endmodule

// File: tb/tb_store_drain_tracker.sv
// tb_store_drain_tracker: directed and random stimulus against a queue-based reference model
module tb_store_drain_tracker;
`ifdef STORE_DRAIN_TRACKER_NC_CNT_EN
  localparam bit NC_EN = 1'b1;
`else
  localparam bit NC_EN = 1'b0;
`endif
  logic clk_i = 1'b0, rst_i = 1'b1, st_valid_i = 1'b0, st_req_ready_i = 1'b0;
  logic st_ack_i = 1'b0, st_ack_cached_i = 1'b0, fence_i = 1'b0;
  logic [33:0] st_addr_i = '0;
  logic st_ready_o, st_req_valid_o, st_req_cached_o, fence_busy_o, fence_done_o, nc_pending_o, err_o;
  logic [33:0] st_req_addr_o;
  logic [2:0] outstanding_o;
  int errors = 0, checks = 0;

  store_drain_tracker dut (
    .clk_i(clk_i), .rst_i(rst_i), .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
    .st_addr_i(st_addr_i), .st_req_valid_o(st_req_valid_o), .st_req_ready_i(st_req_ready_i),
    .st_req_addr_o(st_req_addr_o), .st_req_cached_o(st_req_cached_o), .st_ack_i(st_ack_i),
    .st_ack_cached_i(st_ack_cached_i), .fence_i(fence_i), .fence_busy_o(fence_busy_o),
    .fence_done_o(fence_done_o), .outstanding_o(outstanding_o), .nc_pending_o(nc_pending_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: at most one buffered store, plain integer counters, fence phase 0/1/2
  int m_cnt = 0, m_ncnt = 0, m_phase = 0;
  bit m_err = 0;
  logic [33:0] q_addr[$];
  bit q_cached[$];

  function automatic bit in_region(input logic [33:0] a);
    return (a >= 34'h8000_0000) && (a < 34'hC000_0000);
  endfunction

  always @(negedge clk_i) begin
    bit ev, ei, er, hc;
    int np, d, dn;
    ev = (q_addr.size() != 0) && (m_cnt < 7);
    ei = ev && st_req_ready_i;
    er = (m_phase == 0) && ((q_addr.size() == 0) || ei);
    chk("req_valid", st_req_valid_o, ev);
    chk("st_ready", st_ready_o, er);
    if (ev) begin
      chk("req_addr", st_req_addr_o, q_addr[0]);
      chk("req_cached", st_req_cached_o, q_cached[0]);
    end
    chk("outstanding", outstanding_o, m_cnt);
    chk("err", err_o, m_err);
    chk("fence_busy", fence_busy_o, m_phase != 0);
    chk("fence_done", fence_done_o, m_phase == 2);
    chk("nc_pending", nc_pending_o, NC_EN && (m_ncnt != 0));
    if (rst_i) begin
      m_cnt = 0; m_ncnt = 0; m_phase = 0; m_err = 0;
      q_addr.delete(); q_cached.delete();
    end else begin
      np = (m_phase == 0) ? (fence_i ? 1 : 0) :
           (m_phase == 1) ? (((q_addr.size() == 0) && (m_cnt == 0)) ? 2 : 1) : 0;
      hc = 1'b1;
      if (ei) begin
        hc = q_cached.pop_front();
        void'(q_addr.pop_front());
      end
      d = m_cnt + int'(ei) - int'(st_ack_i);
      if (d < 0) begin m_err = 1; d = 0; end
      m_cnt = d;
      dn = m_ncnt + int'(ei && !hc) - int'(st_ack_i && !st_ack_cached_i);
      m_ncnt = (dn < 0) ? 0 : dn;
      if (st_valid_i && er) begin
        q_addr.push_back(st_addr_i);
        q_cached.push_back(in_region(st_addr_i));
      end
      m_phase = np;
    end
  end

  task automatic drive(input bit r, input bit v, input logic [33:0] a, input bit rd,
                       input bit ak, input bit akc, input bit f);
    @(posedge clk_i);
    #1;
    rst_i = r; st_valid_i = v; st_addr_i = a; st_req_ready_i = rd;
    st_ack_i = ak; st_ack_cached_i = akc; fence_i = f;
  endtask

  task automatic look;
    @(negedge clk_i);
    #2;
  endtask

  task automatic idle;
    drive(0, 0, '0, 0, 0, 0, 0);
  endtask

  logic [33:0] cls_addr[4] = '{34'h8000_0000, 34'h7FFF_FFFF, 34'hC000_0000, 34'hBFFF_FFFF};
  bit cls_exp[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [33:0] edge_addr[4] = '{34'h8000_0000, 34'h7FFF_FFFF, 34'hC000_0000, 34'hBFFF_FFFF};

  initial begin
    drive(1, 0, '0, 0, 0, 0, 0);
    drive(1, 0, '0, 0, 0, 0, 0);
    idle; look;
    chk("rst_ready", st_ready_o, 1);
    chk("rst_busy", fence_busy_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_req_valid", st_req_valid_o, 0);
    idle; look;
    chk("idle_busy", fence_busy_o, 0);

    for (int i = 0; i < 4; i++) begin
      drive(0, 1, cls_addr[i], 0, 0, 0, 0);
      idle; look;
      chk("classify", st_req_cached_o, cls_exp[i]);
      chk("classify_valid", st_req_valid_o, 1);
      drive(0, 0, '0, 1, 0, 0, 0);
      drive(0, 0, '0, 0, 1, cls_exp[i], 0);
    end

    for (int k = 0; k < 8; k++) drive(0, 1, 34'h8000_0000 + 34'(k), 1, 0, 0, 0);
    drive(0, 0, '0, 1, 0, 0, 0); look;
    chk("full_count", outstanding_o, 7);
    chk("full_stall_valid", st_req_valid_o, 0);
    chk("full_stall_ready", st_ready_o, 0);
    drive(0, 0, '0, 1, 1, 1, 0); look;
    chk("full_ack_cycle", outstanding_o, 7);
    drive(0, 0, '0, 1, 0, 0, 0); look;
    chk("full_resume_valid", st_req_valid_o, 1);
    chk("full_resume_count", outstanding_o, 6);
    idle; look;
    chk("full_after", outstanding_o, 7);
    repeat (7) drive(0, 0, '0, 0, 1, 1, 0);
    idle; look;
    chk("full_drained", outstanding_o, 0);

    for (int k = 0; k < 3; k++) drive(0, 1, 34'h8000_0100, 1, 0, 0, 0);
    drive(0, 0, '0, 1, 0, 0, 0);
    drive(0, 1, 34'h8000_0200, 0, 0, 0, 0); look;
    chk("simul_pre", outstanding_o, 3);
    drive(0, 0, '0, 1, 1, 1, 0); look;
    chk("simul_cycle", outstanding_o, 3);
    idle; look;
    chk("simul_after", outstanding_o, 3);
    repeat (3) drive(0, 0, '0, 0, 1, 1, 0);
    drive(0, 0, '0, 0, 1, 1, 0);
    idle; look;
    chk("err_set", err_o, 1);
    chk("err_count", outstanding_o, 0);
    idle; idle; look;
    chk("err_sticky", err_o, 1);

    drive(0, 1, 34'h1000, 1, 0, 0, 0);
    drive(0, 1, 34'h2000, 1, 0, 0, 0);
    drive(0, 0, '0, 1, 0, 0, 0);
    drive(0, 0, '0, 0, 0, 0, 1);
    idle; look;
    chk("fence_busy", fence_busy_o, 1);
    chk("fence_ready", st_ready_o, 0);
    chk("fence_nc", nc_pending_o, NC_EN);
    chk("fence_count", outstanding_o, 2);
    drive(0, 0, '0, 0, 1, 0, 0);
    idle;
    drive(0, 0, '0, 0, 1, 0, 0); look;
    chk("fence_done_k", fence_done_o, 0);
    idle; look;
    chk("fence_done_k1", fence_done_o, 0);
    idle; look;
    chk("fence_done_k2", fence_done_o, 1);
    chk("fence_nc_clear", nc_pending_o, 0);
    idle; look;
    chk("fence_idle_busy", fence_busy_o, 0);
    chk("fence_idle_ready", st_ready_o, 1);

    drive(0, 1, 34'h3000, 1, 0, 0, 0);
    drive(0, 1, 34'h8000_3000, 1, 0, 0, 0);
    drive(0, 0, '0, 1, 0, 0, 0);
    drive(0, 0, '0, 0, 0, 0, 1);
    idle; look;
    chk("rdrain_busy", fence_busy_o, 1);
    chk("rdrain_count", outstanding_o, 2);
    drive(1, 0, '0, 0, 0, 0, 0);
    idle; look;
    chk("rdrain_busy_after", fence_busy_o, 0);
    chk("rdrain_count_after", outstanding_o, 0);
    chk("rdrain_done", fence_done_o, 0);
    chk("rdrain_err", err_o, 0);
    idle; look;
    chk("rdrain_done_later", fence_done_o, 0);

    for (int n = 0; n < 3000; n++) begin
      logic [33:0] a;
      a = ($urandom_range(0, 1) == 0) ? edge_addr[$urandom_range(0, 3)]
                                      : {2'($urandom_range(0, 3)), 32'($urandom)};
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, a,
            $urandom_range(0, 3) != 0, (m_cnt > 0) && ($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end
    idle; look;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
